negator_seq: RTL
================

# negator_seq

Parametrised, bit-serial negator; successor to the 4-bit combinational inverter. Negates a WIDTH-bit operand LSB-first, one bit per clock, in one's-complement (bitwise NOT) or two's-complement (arithmetic negate) mode. A start/busy/done handshake lets a small controller or lab top level issue operations. It flags the single overflowing two's-complement input.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when the block is idle or in its done cycle.
- mode  input  1  0 = one's complement, 1 = two's complement; latched with start.
- a  input  WIDTH  operand; latched with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; b and ovf are valid from this cycle onward.
- b  output  WIDTH  result register; holds the last result until the next done.
- ovf  output  1  two's-complement overflow: mode=1 and a = 1 followed by WIDTH-1 zeros.

## Operation
- States are IDLE, SHIFT and DONE.
- **IDLE:**
  - start=1 latches a into the shift register and latches mode.
  - Clears the bit counter and the seen_one flag.
  - Next state is SHIFT.
- **SHIFT:**
  - Each cycle consumes the operand LSB, emits one result bit into the result shift register, and increments the counter.
  - Mode 0: out = ~in.
  - Mode 1: out = in ^ seen_one, then seen_one |= in. This is the copy-through-first-1, then-invert rule.
  - After the WIDTH-th bit, the block copies the assembled result into b, computes ovf, and goes to DONE.
- **DONE:**
  - done=1 for exactly one cycle.
  - With start=1, the block re-latches and goes to SHIFT, so back-to-back operations are allowed.
  - Otherwise it goes to IDLE.
- start while in SHIFT is ignored; the request is not queued.
- ovf = mode & (a == 2^(WIDTH-1)). In that case b equals a, which is the wrap-around result.
- Two's complement of 0 gives b = 0 and ovf = 0, because seen_one never sets.
- ovf is 0 for every one's-complement result.
- b and ovf change only on the edge that enters DONE. They are not disturbed during SHIFT.
- Reset, asserted at any time including mid-operation:
  - State goes to IDLE.
  - busy = done = ovf = 0 and b = 0.
  - Counter, seen_one and shift registers are cleared.
  - A partial result is discarded and never appears on b.

## Timing
- Edge k samples start=1 in IDLE or DONE. busy=1 from after edge k.
- Edges k+1 through k+WIDTH process bits 0 through WIDTH-1.
- Edge k+WIDTH updates b and ovf, sets done=1 and clears busy.
- Edge k+WIDTH+1 clears done (unless start re-triggers).
- Latency from the start sample to done is WIDTH edges. Sustained throughput is one operation per WIDTH+1 cycles.
- busy and done are never high together. All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package negator_pkg contains:
  - The state enum (IDLE, SHIFT, DONE).
  - MODE_ONES = 1'b0 and MODE_TWOS = 1'b1.
  - A counter-width function clog2(WIDTH+1).
- One sub-module, negator_bit_cell:
  - Combinational one-bit serial cell.
  - Inputs: in, mode, seen_one. Outputs: out, seen_one_next.
  - Instantiated once and reused every cycle.
- The top level holds the FSM, counter, operand and result shift registers, and the output registers.

## Test plan
- Reset: drive rst_n=0 with random inputs, then release. Require b=0, busy=0, done=0, ovf=0, and no done pulse without start.
- One's complement, WIDTH=8: a=8'h5A, mode=0, start for one cycle. Require busy for 8 cycles, done on the 8th edge, b=8'hA5, ovf=0.
- Two's complement, WIDTH=8, each vector as its own operation:
  - a=8'h01 gives b=8'hFF.
  - a=8'h00 gives b=8'h00, ovf=0.
  - a=8'h80 gives b=8'h80, ovf=1.
  - a=8'h7F gives b=8'h81.
- Handshake: pulse start mid-SHIFT and require it to be ignored. Assert start during the DONE cycle and require the next operation to begin immediately, with done pulses 9 cycles apart.
- Reset mid-operation: assert rst_n=0 at bit 4 of a=8'h3C, mode=1. Require outputs cleared and no done. A subsequent start with a=8'h3C must give b=8'hC4.
- Width sweep: WIDTH=2, 4, 16 and 32, exhaustive or random operands in both modes. Compare against ~a and -a, and check ovf only for the MSB-only pattern.

Source files
------------

// File: rtl/negator_pkg.sv
// Shared types and helpers for the bit-serial negator.
// No logic; no latency.
// No flow control; constants and a width helper only.
package negator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_ONES = 1'b0;
    localparam logic MODE_TWOS = 1'b1;

    // Counter must hold the value WIDTH once the last bit is consumed.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/negator_bit_cell.sv
// One-bit serial negation cell: bitwise NOT or copy-through-first-1 then invert.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller steps it once per processed bit.
module negator_bit_cell
    import negator_pkg::*;
(
    input  logic in_bit,
    input  logic mode,
    input  logic seen_one,
    output logic out_bit,
    output logic seen_one_next
);

    always_comb begin
        out_bit       = ~in_bit;
        seen_one_next = seen_one | in_bit;
        if (mode == MODE_TWOS) begin
            out_bit = in_bit ^ seen_one;
        end
    end

endmodule

// File: rtl/negator_seq.sv
// Bit-serial WIDTH-bit negator (one's or two's complement), LSB first.
// Latency: WIDTH cycles from the start sample to the done pulse.
// Backpressure: start accepted only in IDLE or DONE; start during SHIFT is dropped, not queued.
module negator_seq
    import negator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] b,
    output logic             ovf
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic             seen_q, seen_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic cell_out;
    logic cell_seen_next;

    negator_bit_cell u_cell (
        .in_bit        (opnd_q[0]),
        .mode          (mode_q),
        .seen_one      (seen_q),
        .out_bit       (cell_out),
        .seen_one_next (cell_seen_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        b_d     = b_q;
        mode_d  = mode_q;
        seen_d  = seen_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    opnd_d  = a;
                    mode_d  = mode;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                    res_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                opnd_d = opnd_q >> 1;
                res_d  = {cell_out, res_q[WIDTH-1:1]};
                seen_d = cell_seen_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    b_d     = res_d;
                    // Overflow iff the MSB is the first and only 1 seen in two's mode.
                    ovf_d   = (mode_q == MODE_TWOS) && !seen_q && opnd_q[0];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            b_q     <= '0;
            mode_q  <= MODE_ONES;
            seen_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign b    = b_q;
    assign ovf  = ovf_q;

endmodule
